i2s_stereo_tx: RTL

//  Stereo I2S transmitter: accepts one {left,right} 24-bit sample pair per valid/ready handshake.

---
 rtl/i2s_pkg.sv | 21 ++
 rtl/i2s_if.sv | 34 +++
 rtl/i2s_clk_gen.sv | 52 +++++
 rtl/i2s_stereo_tx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared constants and types for the stereo I2S transmitter.
//   DATA_W          default sample width per channel
//   SLOTS_PER_CH    SCLK periods per channel (one word-select half)
//   SLOTS_PER_FRAME SCLK periods per full left+right frame
//   stereo_t        one {left,right} sample pair at the default width
// Optional feature macro used by this block: I2S_TX_UNDERRUN_CNT_EN
// ---------------------------------------------------------------------------
package i2s_pkg;

   localparam int DATA_W          = 24;
   localparam int SLOTS_PER_CH    = 32;
   localparam int SLOTS_PER_FRAME = 2 * SLOTS_PER_CH;

   typedef struct packed {
      logic [DATA_W-1:0] left;
      logic [DATA_W-1:0] right;
   } stereo_t;

endpackage

// File: rtl/i2s_if.sv
// ---------------------------------------------------------------------------
// i2s_if
// Valid/ready sample-pair stream feeding the I2S transmitter.
//   valid_i       producer has a pair on the data lines
//   ready_o       transmitter holding register is empty
//   data_left_i   left sample, two's complement
//   data_right_i  right sample, two's complement
// The master modport is the producer (filter pipeline), the slave modport is
// the transmitter. Signal names keep the transmitter's point of view.
// ---------------------------------------------------------------------------
interface i2s_if #(
   parameter int DATA_W = i2s_pkg::DATA_W
);

   logic              valid_i;
   logic              ready_o;
   logic [DATA_W-1:0] data_left_i;
   logic [DATA_W-1:0] data_right_i;

   modport master (
      output valid_i,
      output data_left_i,
      output data_right_i,
      input  ready_o
   );

   modport slave (
      input  valid_i,
      input  data_left_i,
      input  data_right_i,
      output ready_o
   );

endinterface

// File: rtl/i2s_clk_gen.sv
// ---------------------------------------------------------------------------
// i2s_clk_gen
// Free-running frame counter and the I2S timing signals derived from it.
// Ports:
//   clk_i        system clock
//   reset_n_i    asynchronous active-low reset
//   sclk_o       serial bit clock, period 2**SCLK_LOG2 clk_i cycles
//   lrck_o       word select, 0 = left half, 1 = right half
//   bit_adv_o    high on the last clk_i cycle of every SCLK period
//                (the cycle before SCLK falls)
//   frame_end_o  high on the last clk_i cycle of the frame (counter all ones)
// ---------------------------------------------------------------------------
module i2s_clk_gen #(
   parameter int SCLK_LOG2 = 3
) (
   input  logic clk_i,
   input  logic reset_n_i,
   output logic sclk_o,
   output logic lrck_o,
   output logic bit_adv_o,
   output logic frame_end_o
);

   import i2s_pkg::*;

   localparam int CNT_W = SCLK_LOG2 + $clog2(SLOTS_PER_FRAME);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The counter simply wraps at all ones; one full wrap is one I2S frame.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // SCLK and LRCK are straight counter bits, so they are glitch-free flop
   // outputs. The strobes mark the cycle just before the next SCLK falling
   // edge, which is where the serial data register has to be updated.
   assign sclk_o      = cnt_q[SCLK_LOG2-1];
   assign lrck_o      = cnt_q[CNT_W-1];
   assign bit_adv_o   = &cnt_q[SCLK_LOG2-1:0];
   assign frame_end_o = &cnt_q;

endmodule

// File: rtl/i2s_stereo_tx.sv
// ---------------------------------------------------------------------------
// i2s_stereo_tx
// Stereo I2S (Philips format) transmitter. Takes one {left,right} pair per
// valid/ready handshake into a one-entry holding register and sends it as a
// 64-SCLK frame: per channel, slot 0 is the one-bit I2S delay, slots
// 1..DATA_W carry the sample MSB first, remaining slots are zero.
// Ports:
//   clk_i             system clock
//   reset_n_i         asynchronous active-low reset
//   in_if             i2s_if slave: valid_i, ready_o, data_left_i, data_right_i
//   sclk_o            serial bit clock
//   lrck_o            word select, 0 = left, 1 = right
//   sdata_o           serial data, changes with the SCLK falling edge
//   underrun_o        one-cycle pulse on a frame load that found no pair
//   underrun_count_o  (only with I2S_TX_UNDERRUN_CNT_EN) saturating count of
//                     underrun_o pulses, cleared only by reset
// Optional feature macro: I2S_TX_UNDERRUN_CNT_EN
// ---------------------------------------------------------------------------
module i2s_stereo_tx #(
   parameter int DATA_W    = 24,
   parameter int SCLK_LOG2 = 3
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   i2s_if.slave        in_if,
   output logic        sclk_o,
   output logic        lrck_o,
   output logic        sdata_o,
   output logic        underrun_o
`ifdef I2S_TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0] underrun_count_o
`endif
);

   import i2s_pkg::*;

   localparam int FRAME_W = 2 * SLOTS_PER_CH;

   typedef struct packed {
      logic [DATA_W-1:0] left;
      logic [DATA_W-1:0] right;
   } pair_t;

   logic                    bit_adv;
   logic                    frame_end;
   logic                    accept;
   pair_t                   hold_q;
   pair_t                   hold_d;
   logic                    hold_v_q;
   logic                    hold_v_d;
   logic [FRAME_W-1:0]      frame_q;
   logic [FRAME_W-1:0]      frame_d;
   logic                    sdata_q;
   logic                    sdata_d;
   logic [SLOTS_PER_CH-1:0] left_word;
   logic [SLOTS_PER_CH-1:0] right_word;

   i2s_clk_gen #(
      .SCLK_LOG2   (SCLK_LOG2)
   ) u_clk_gen (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .sclk_o      (sclk_o),
      .lrck_o      (lrck_o),
      .bit_adv_o   (bit_adv),
      .frame_end_o (frame_end)
   );

   assign in_if.ready_o = ~hold_v_q;
   assign accept        = in_if.valid_i & ~hold_v_q;

   // A channel word is the sample left-justified one slot below the top:
   // bit 31 (slot 0) stays zero for the I2S delay, the low slots pad with zero.
   assign left_word  = SLOTS_PER_CH'(hold_q.left)  << (SLOTS_PER_CH - 1 - DATA_W);
   assign right_word = SLOTS_PER_CH'(hold_q.right) << (SLOTS_PER_CH - 1 - DATA_W);

   // Holding register, frame shift register and serial data.
   // Accept and frame load never collide on hold_v: accept needs it clear and
   // the load only consumes it when set. A pair accepted on the load cycle is
   // therefore not bypassed; that frame goes out as zeros and the pair waits
   // one frame. The shift register is left-shifted once per SCLK period and
   // sdata takes the new MSB, so slot 0 of a freshly loaded frame is output
   // right after the load.
   always_comb begin
      hold_d   = hold_q;
      hold_v_d = hold_v_q;
      frame_d  = frame_q;
      sdata_d  = sdata_q;

      if (accept) begin
         hold_d   = '{left: in_if.data_left_i, right: in_if.data_right_i};
         hold_v_d = 1'b1;
      end

      if (frame_end) begin
         if (hold_v_q) begin
            frame_d  = {left_word, right_word};
            hold_v_d = 1'b0;
         end else begin
            frame_d = '0;
         end
      end else if (bit_adv) begin
         frame_d = frame_q << 1;
      end

      if (bit_adv) begin
         sdata_d = frame_d[FRAME_W-1];
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         hold_q   <= '0;
         hold_v_q <= 1'b0;
         frame_q  <= '0;
         sdata_q  <= 1'b0;
      end else begin
         hold_q   <= hold_d;
         hold_v_q <= hold_v_d;
         frame_q  <= frame_d;
         sdata_q  <= sdata_d;
      end
   end

   assign sdata_o    = sdata_q;
   assign underrun_o = frame_end & ~hold_v_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
   logic [15:0] urun_cnt_q;
   logic [15:0] urun_cnt_d;

   // Saturating underrun counter; it stops at all ones rather than wrapping
   // so a long starvation period is never reported as a small number.
   always_comb begin
      urun_cnt_d = urun_cnt_q;
      if (underrun_o && (urun_cnt_q != 16'hFFFF)) begin
         urun_cnt_d = urun_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         urun_cnt_q <= '0;
      end else begin
         urun_cnt_q <= urun_cnt_d;
      end
   end

   assign underrun_count_o = urun_cnt_q;
`endif

endmodule
